// File: rtl/bitmix_rr_scheduler.sv
// bitmix_rr_scheduler
// Round-robin scheduler that shares one 4-bit bit-remap unit between NREQ
// requesters. Only one transaction is in flight at a time.
// Transaction flow: IDLE accepts a request, EXEC computes the result,
// RSP holds the tagged response until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req_valid  per-requester request valid            [NREQ]
//   req_data   per-requester operand, lane i = [4i+3:4i] [4*NREQ]
//   req_ready  per-requester accept, at most one bit high [NREQ]
//   rsp_valid  response valid
//   rsp_ready  consumer ready
//   rsp_data   transformed word                       [4]
//   rsp_and    AND-reduction of rsp_data
//   rsp_id     requester index of the response        [IDW]
//   busy       high whenever the FSM is not in IDLE
//   done_cnt   completed responses, wraps             [CNTW]
module bitmix_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [4*NREQ-1:0]    req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [3:0]           rsp_data,
   output logic                 rsp_and,
   output logic [IDW-1:0]       rsp_id,
   output logic                 busy,
   output logic [CNTW-1:0]      done_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RSP} state_t;

   state_t            r_state;
   logic [IDW-1:0]    r_ptr;
   logic [IDW-1:0]    r_id;
   logic [3:0]        r_op;
   logic [3:0]        r_rsp_data;
   logic              r_rsp_and;
   logic [IDW-1:0]    r_rsp_id;
   logic [CNTW-1:0]   r_done_cnt;

   logic              w_gnt_vld;
   logic [IDW-1:0]    w_gnt;
   logic [IDW:0]      w_sum;
   logic [IDW-1:0]    w_ptr_nxt;
   logic              w_accept;
   logic [3:0]        w_f;

   // Bit remap: MSB passes through, the two middle bits are its inverse,
   // LSB is tied high.
   function automatic logic [3:0] bitmix(input logic [3:0] x);
      return {x[3], ~x[3], ~x[3], 1'b1};
   endfunction

   // Search ptr, ptr+1, ... (mod NREQ); iterating from the far end lets the
   // nearest valid requester overwrite any farther candidate.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_sum     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
         if (w_sum >= (IDW+1)'(NREQ))
            w_sum = w_sum - (IDW+1)'(NREQ);
         if (req_valid[w_sum[IDW-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_sum[IDW-1:0];
         end
      end
   end

   assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);
   assign w_accept  = (r_state == S_IDLE) && !rst && w_gnt_vld;
   assign req_ready = w_accept ? (NREQ'(1) << w_gnt) : '0;
   assign w_f       = bitmix(r_op);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_done_cnt <= '0;
         r_rsp_data <= '0;
         r_rsp_and  <= 1'b0;
         r_rsp_id   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op    <= req_data[{w_gnt, 2'b00} +: 4];
                  r_id    <= w_gnt;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_data <= w_f;
               r_rsp_and  <= &w_f;
               r_rsp_id   <= r_id;
               r_state    <= S_RSP;
            end
            S_RSP: begin
               if (rsp_ready) begin
                  r_done_cnt <= r_done_cnt + CNTW'(1);
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = (r_state == S_RSP);
   assign busy      = (r_state != S_IDLE);
   assign rsp_data  = r_rsp_data;
   assign rsp_and   = r_rsp_and;
   assign rsp_id    = r_rsp_id;
   assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_bitmix_rr_scheduler.sv
// Directed bench for bitmix_rr_scheduler with a response scoreboard.
module tb_bitmix_rr_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [3:0]  rsp_data;
   logic        rsp_and;
   logic [1:0]  rsp_id;
   logic        busy;
   logic [7:0]  done_cnt;

   bitmix_rr_scheduler #(.NREQ(4), .IDW(2), .CNTW(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_and(rsp_and), .rsp_id(rsp_id),
      .busy(busy), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] data;
      logic [1:0] id;
   } exp_t;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_cnt;
   int         exp_ptr;

   function automatic logic [3:0] model_f(input logic [3:0] x);
      return x[3] ? 4'b1001 : 4'b0111;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Expected grant from the bench's own pointer model.
   function automatic int model_grant(input logic [3:0] mask);
      int g;
      g = -1;
      for (int k = 0; k < 4; k++)
         if (g < 0 && mask[(exp_ptr + k) % 4]) g = (exp_ptr + k) % 4;
      return g;
   endfunction

   task automatic push_exp(input int g, input logic [15:0] lanes);
      exp_t e;
      e.data = model_f(lanes[4*g +: 4]);
      e.id   = 2'(g);
      sb.push_back(e);
      exp_ptr = (g + 1) % 4;
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(sb.size()), 1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_data"}, 32'(rsp_data), 32'(e.data));
         chk({tag, "_and"},  32'(rsp_and),  32'(&e.data));
         chk({tag, "_id"},   32'(rsp_id),   32'(e.id));
      end
   endtask

   // One full transaction with rsp_ready held high.
   task automatic do_txn(input string tag, input logic [3:0] mask,
                         input logic [15:0] lanes, input bit hold);
      int g;
      req_valid = mask;
      req_data  = lanes;
      rsp_ready = 1'b1;
      settle();
      g = model_grant(mask);
      chk({tag, "_onehot"}, 32'($countones(req_ready) <= 1), 1);
      chk({tag, "_grant"}, 32'(req_ready), 32'(1 << g));
      push_exp(g, lanes);
      step();
      if (!hold) req_valid = 4'b0000;
      settle();
      chk({tag, "_exec_vld"}, 32'(rsp_valid), 0);
      chk({tag, "_exec_busy"}, 32'(busy), 1);
      chk({tag, "_exec_rdy"}, 32'(req_ready), 0);
      step();
      chk({tag, "_rsp_vld"}, 32'(rsp_valid), 1);
      pop_cmp(tag);
      step();
      exp_cnt++;
      chk({tag, "_cnt"}, 32'(done_cnt), 32'(exp_cnt));
      chk({tag, "_idle_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int g;
      logic [15:0] lanes;
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_data  = 16'h0;
      rsp_ready = 1'b0;
      exp_ptr   = 0;
      exp_cnt   = 8'd0;
      step();
      step();
      // Reset state, with every requester valid.
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cnt", 32'(done_cnt), 0);
      chk("rst_data", 32'(rsp_data), 0);
      chk("rst_and", 32'(rsp_and), 0);
      chk("rst_id", 32'(rsp_id), 0);

      // Reset during EXEC drops the transaction.
      req_valid = 4'b0010;
      req_data  = 16'h00F0;
      rst       = 1'b0;
      settle();
      chk("midrst_grant", 32'(req_ready), 32'(4'b0010));
      step();
      req_valid = 4'b0000;
      rst       = 1'b1;
      settle();
      chk("midrst_busy_before", 32'(busy), 1);
      step();
      rst = 1'b0;
      settle();
      chk("midrst_rsp_valid", 32'(rsp_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_cnt", 32'(done_cnt), 0);
      step();
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
      req_valid = 4'b1111;
      settle();
      chk("midrst_ptr0", 32'(req_ready), 32'(4'b0001));
      req_valid = 4'b0000;
      exp_ptr   = 0;
      exp_cnt   = 8'd0;
      step();

      // Single request, MSB set.
      do_txn("single", 4'b0100, 16'h0A00, 1'b0);
      // Operand with MSB clear on requester 0.
      do_txn("msb0", 4'b0001, 16'h0006, 1'b0);

      // Round robin from a fresh pointer: expect 0,1,2,3,0,1.
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_ptr = 0;
      exp_cnt = 8'd0;
      for (int n = 0; n < 6; n++) begin
         chk("rr_order", 32'(model_grant(4'b1111)), 32'(n % 4));
         do_txn("rr", 4'b1111, 16'(16'h8C31 + 16'(n * 16'h1357)), 1'b1);
      end
      req_valid = 4'b0000;

      // Backpressure in RSP.
      lanes     = 16'hB000;
      req_valid = 4'b1000;
      req_data  = lanes;
      rsp_ready = 1'b0;
      settle();
      g = model_grant(4'b1000);
      chk("bp_grant", 32'(req_ready), 32'(1 << g));
      push_exp(g, lanes);
      step();
      req_valid = 4'b1111;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_data", 32'(rsp_data), 32'(model_f(lanes[15:12])));
         chk("bp_id", 32'(rsp_id), 3);
         chk("bp_ready", 32'(req_ready), 0);
         chk("bp_cnt", 32'(done_cnt), 32'(exp_cnt));
         step();
      end
      pop_cmp("bp");
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      step();
      exp_cnt++;
      chk("bp_cnt_done", 32'(done_cnt), 32'(exp_cnt));
      chk("bp_idle", 32'(rsp_valid), 0);

      // Counter wrap.
      while (exp_cnt != 8'd0)
         do_txn("wrap", 4'b1111, 16'($urandom), 1'b1);
      chk("wrap_zero", 32'(done_cnt), 0);
      do_txn("wrap_next", 4'b1111, 16'($urandom), 1'b1);
      chk("wrap_one", 32'(done_cnt), 1);
      req_valid = 4'b0000;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
